result_collector: RTL

Downstream companion to the a×b×c+d multiply-add pipeline. The pipeline has no valid or stall signals, so this block tracks which cycles carry real operands with a valid tag delay line matched to the pipeline latency. It captures each genuine result into a small FIFO and presents the results on a ready/valid stream. Results that arrive while the FIFO is full are dropped and reported.

---
 rtl/result_pkg.sv | 13 +
 rtl/result_fifo.sv | 52 +++++
 rtl/result_collector.sv | 81 ++++++++
 3 files changed

// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - default sizing constants and count-width helper for result_collector
package result_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_DEPTH   = 8;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO with storage, wrapping pointers and count-based full/empty
module result_fifo
  import result_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately not reset; only the bookkeeping below is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks net occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - valid-tag delay line plus result FIFO behind the multiply-add pipeline; RESULT_DROP_COUNT_EN adds drop_count
module result_collector
  import result_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue,
  input  logic [WIDTH-1:0]       result,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clear
`ifdef RESULT_DROP_COUNT_EN
  ,
  output logic [7:0]             drop_count
`endif
);

  logic [LATENCY-1:0] tag;
  logic               wr_req;
  logic               rd;
  logic               wr_ok;
  logic               drop;
  logic               full;
  logic               empty;

  // Delay the issue marker so it lines up with the pipeline's output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag[0] <= issue;
      for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
    end
  end

  assign wr_req  = tag[LATENCY-1];
  assign rd      = m_valid && m_ready;
  // A read on the same edge frees the slot the incoming write needs.
  assign wr_ok   = wr_req && (!full || rd);
  assign drop    = wr_req && full && !rd;
  assign m_valid = !empty;

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_data (result),
    .rd_en   (rd),
    .rd_data (m_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Sticky drop flag; a drop on the same edge as clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
    else if (clear) overflow <= 1'b0;
  end

`ifdef RESULT_DROP_COUNT_EN
  // Saturating drop tally; clear restarts it, counting a coincident drop as the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           drop_count <= 8'd0;
    else if (clear)                       drop_count <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule
